// File: rtl/int_pipe_mc.sv
// rtl/int_pipe_mc.sv - multi-lane integer execution pipe with iterative unsigned divide/remainder
// Single-cycle ALU results travel a STAGES-deep pipe; the divider yields the output slot to them.
module int_pipe_mc #(
   parameter int TILE_ID  = 0,
   parameter int NUM_LANE = 16,
   parameter int DATA_W   = 32,
   parameter int STAGES   = 1,
   parameter int TID_W    = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       opf_valid,
   input  logic [3:0]                 opf_op,
   input  logic [TID_W-1:0]           opf_thread_id,
   input  logic [NUM_LANE*DATA_W-1:0] opf_op0,
   input  logic [NUM_LANE*DATA_W-1:0] opf_op1,
   input  logic [NUM_LANE-1:0]        opf_hw_lane_mask,
   output logic                       int_div_ready,
   output logic                       int_valid,
   output logic [TID_W-1:0]           int_thread_id,
   output logic [NUM_LANE*DATA_W-1:0] int_result,
   output logic [NUM_LANE-1:0]        int_hw_lane_mask,
   output logic                       int_error
);

   localparam int VEC_W = NUM_LANE * DATA_W;
   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = $clog2(DATA_W);

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_AND    = 4'd2;
   localparam logic [3:0] OP_OR     = 4'd3;
   localparam logic [3:0] OP_XOR    = 4'd4;
   localparam logic [3:0] OP_SHL    = 4'd5;
   localparam logic [3:0] OP_SHR    = 4'd6;
   localparam logic [3:0] OP_ASHR   = 4'd7;
   localparam logic [3:0] OP_CMPEQ  = 4'd8;
   localparam logic [3:0] OP_CMPLT  = 4'd9;
   localparam logic [3:0] OP_CMPLTU = 4'd10;
   localparam logic [3:0] OP_MOVE   = 4'd11;
   localparam logic [3:0] OP_DIVU   = 4'd12;
   localparam logic [3:0] OP_REMU   = 4'd13;

   typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

   div_state_t div_state, div_state_nx;

   logic              pipe_valid [STAGES];
   logic [TID_W-1:0]  pipe_tid   [STAGES];
   logic [VEC_W-1:0]  pipe_data  [STAGES];
   logic [NUM_LANE-1:0] pipe_mask [STAGES];

   logic [VEC_W-1:0]    alu_res;
   logic [NUM_LANE-1:0] cmp_bits;

   logic [VEC_W-1:0]    div_q, div_r, div_d, step_q, step_r;
   logic [DATA_W:0]     trial;
   logic [NUM_LANE-1:0] div_mask;
   logic [TID_W-1:0]    div_tid;
   logic                div_is_rem;
   logic [CNT_W-1:0]    div_cnt;

   logic is_div_op, div_issue, div_reject, div_present, last_valid;

   function automatic logic [DATA_W-1:0] lane_alu(input logic [3:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [SH_W-1:0] sh;
      sh = b[SH_W-1:0];
      case (op)
         OP_ADD:  lane_alu = a + b;
         OP_SUB:  lane_alu = a - b;
         OP_AND:  lane_alu = a & b;
         OP_OR:   lane_alu = a | b;
         OP_XOR:  lane_alu = a ^ b;
         OP_SHL:  lane_alu = a << sh;
         OP_SHR:  lane_alu = a >> sh;
         OP_ASHR: lane_alu = $signed(a) >>> sh;
         OP_MOVE: lane_alu = b;
         default: lane_alu = '0;
      endcase
   endfunction

   function automatic logic lane_cmp(input logic [3:0] op,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
      case (op)
         OP_CMPEQ:  lane_cmp = (a == b);
         OP_CMPLT:  lane_cmp = ($signed(a) < $signed(b));
         OP_CMPLTU: lane_cmp = (a < b);
         default:   lane_cmp = 1'b0;
      endcase
   endfunction

   always_comb begin
      alu_res  = '0;
      cmp_bits = '0;
      for (int l = 0; l < NUM_LANE; l++) begin
         alu_res[l*DATA_W +: DATA_W] = lane_alu(opf_op, opf_op0[l*DATA_W +: DATA_W],
                                                opf_op1[l*DATA_W +: DATA_W]);
         cmp_bits[l] = lane_cmp(opf_op, opf_op0[l*DATA_W +: DATA_W],
                                opf_op1[l*DATA_W +: DATA_W]);
      end
      // compares gather one bit per lane into lane 0
      if (opf_op inside {OP_CMPEQ, OP_CMPLT, OP_CMPLTU}) begin
         alu_res = '0;
         alu_res[DATA_W-1:0] = DATA_W'(cmp_bits);
      end
   end

   // one restoring-division step per lane: shift in the next dividend bit, subtract if it fits
   always_comb begin
      step_q = '0;
      step_r = '0;
      trial  = '0;
      for (int l = 0; l < NUM_LANE; l++) begin
         trial = {div_r[l*DATA_W +: DATA_W], div_q[l*DATA_W + DATA_W - 1]};
         if (trial >= {1'b0, div_d[l*DATA_W +: DATA_W]}) begin
            step_r[l*DATA_W +: DATA_W] = DATA_W'(trial - {1'b0, div_d[l*DATA_W +: DATA_W]});
            step_q[l*DATA_W +: DATA_W] = {div_q[l*DATA_W +: DATA_W-1], 1'b1};
         end else begin
            step_r[l*DATA_W +: DATA_W] = trial[DATA_W-1:0];
            step_q[l*DATA_W +: DATA_W] = {div_q[l*DATA_W +: DATA_W-1], 1'b0};
         end
      end
   end

   assign is_div_op  = (opf_op == OP_DIVU) || (opf_op == OP_REMU);
   assign last_valid = pipe_valid[STAGES-1];
   assign div_issue  = enable & opf_valid & is_div_op & (div_state == DIV_IDLE);
   assign div_reject = opf_valid & is_div_op & (div_state != DIV_IDLE);

   always_comb begin
      div_state_nx = div_state;
      div_present  = 1'b0;
      case (div_state)
         DIV_IDLE: if (div_issue) div_state_nx = DIV_RUN;
         DIV_RUN:  if (div_cnt == CNT_W'(DATA_W - 1)) div_state_nx = DIV_DONE;
         DIV_DONE: begin
            if (!last_valid) begin
               div_present  = 1'b1;
               div_state_nx = DIV_IDLE;
            end
         end
         default:  div_state_nx = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_state <= DIV_IDLE;
         int_error <= 1'b0;
         for (int s = 0; s < STAGES; s++) pipe_valid[s] <= 1'b0;
      end else if (enable) begin
         div_state     <= div_state_nx;
         int_error     <= div_reject;
         pipe_valid[0] <= opf_valid & ~is_div_op;
         for (int s = 1; s < STAGES; s++) pipe_valid[s] <= pipe_valid[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (enable) begin
         pipe_tid[0]  <= opf_thread_id;
         pipe_data[0] <= alu_res;
         pipe_mask[0] <= opf_hw_lane_mask;
         for (int s = 1; s < STAGES; s++) begin
            pipe_tid[s]  <= pipe_tid[s-1];
            pipe_data[s] <= pipe_data[s-1];
            pipe_mask[s] <= pipe_mask[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (div_issue) begin
         div_q      <= opf_op0;
         div_r      <= '0;
         div_d      <= opf_op1;
         div_mask   <= opf_hw_lane_mask;
         div_tid    <= opf_thread_id;
         div_is_rem <= (opf_op == OP_REMU);
         div_cnt    <= '0;
      end else if (enable && div_state == DIV_RUN) begin
         div_q   <= step_q;
         div_r   <= step_r;
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // pipe wins the output slot; a finished division waits in DONE for a gap
   assign int_div_ready    = (div_state == DIV_IDLE);
   assign int_valid        = last_valid | (div_state == DIV_DONE);
   assign int_thread_id    = last_valid ? pipe_tid[STAGES-1]  : div_tid;
   assign int_hw_lane_mask = last_valid ? pipe_mask[STAGES-1] : div_mask;
   assign int_result       = last_valid ? pipe_data[STAGES-1] : (div_is_rem ? div_r : div_q);

   a_result_known: assert property (@(posedge clk) disable iff (reset)
                                    int_valid |-> !$isunknown(int_result))
      else $error("int_pipe_mc tile %0d: unknown bits on int_result", TILE_ID);

endmodule

// File: tb/tb_int_pipe_mc.sv
// tb/tb_int_pipe_mc.sv - self-checking bench for int_pipe_mc against a queue-based reference model
module tb_int_pipe_mc;

   localparam int NL = 4;
   localparam int DW = 32;
   localparam int ST = 2;
   localparam int TW = 2;
   localparam int VW = NL * DW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b1;
   logic          opf_valid = 1'b0;
   logic [3:0]    opf_op = '0;
   logic [TW-1:0] opf_thread_id = '0;
   logic [VW-1:0] opf_op0 = '0;
   logic [VW-1:0] opf_op1 = '0;
   logic [NL-1:0] opf_hw_lane_mask = '0;
   logic          int_div_ready, int_valid, int_error;
   logic [TW-1:0] int_thread_id;
   logic [VW-1:0] int_result;
   logic [NL-1:0] int_hw_lane_mask;

   int total = 0;
   int bad = 0;

   int_pipe_mc #(.TILE_ID(0), .NUM_LANE(NL), .DATA_W(DW), .STAGES(ST), .TID_W(TW)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .opf_valid(opf_valid), .opf_op(opf_op), .opf_thread_id(opf_thread_id),
      .opf_op0(opf_op0), .opf_op1(opf_op1), .opf_hw_lane_mask(opf_hw_lane_mask),
      .int_div_ready(int_div_ready), .int_valid(int_valid), .int_thread_id(int_thread_id),
      .int_result(int_result), .int_hw_lane_mask(int_hw_lane_mask), .int_error(int_error)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endfunction

   function automatic logic [VW-1:0] ref_alu(input logic [3:0] op, input logic [VW-1:0] a,
                                             input logic [VW-1:0] b);
      logic [VW-1:0] r;
      logic [DW-1:0] x, y, z;
      int sh;
      r = '0;
      for (int l = 0; l < NL; l++) begin
         x = a[l*DW +: DW];
         y = b[l*DW +: DW];
         sh = int'(y % DW);
         z = '0;
         case (op)
            4'd0:  z = x + y;
            4'd1:  z = x - y;
            4'd2:  z = x & y;
            4'd3:  z = x | y;
            4'd4:  z = x ^ y;
            4'd5:  z = x << sh;
            4'd6:  z = x >> sh;
            4'd7:  z = $signed(x) >>> sh;
            4'd8:  r[l] = (x == y);
            4'd9:  r[l] = ($signed(x) < $signed(y));
            4'd10: r[l] = (x < y);
            4'd11: z = y;
            4'd12: z = (y == 0) ? {DW{1'b1}} : x / y;
            4'd13: z = (y == 0) ? x : x % y;
            default: z = '0;
         endcase
         if (op < 4'd8 || op > 4'd10) r[l*DW +: DW] = z;
      end
      return r;
   endfunction

   typedef struct {
      int            due;
      logic [TW-1:0] tid;
      logic [VW-1:0] res;
      logic [NL-1:0] mask;
   } ent_t;

   ent_t sq[$];
   int   ec = 0;
   bit   m_busy = 0, m_pres = 0, rb, isd;
   int   m_due = 0;
   logic [TW-1:0] m_tid;
   logic [VW-1:0] m_res;
   logic [NL-1:0] m_mask;
   logic          exp_valid = 1'b0, exp_err = 1'b0, exp_ready = 1'b1;
   logic [TW-1:0] exp_tid = '0;
   logic [VW-1:0] exp_res = '0;
   logic [NL-1:0] exp_mask = '0;

   // reference model: enabled-edge counter, in-order result queue, single divider slot
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sq.delete();
         m_busy = 0; m_pres = 0; ec = 0;
         exp_valid = 1'b0; exp_err = 1'b0; exp_ready = 1'b1;
      end else if (enable) begin
         rb = !m_busy;
         if (m_pres) begin m_busy = 0; m_pres = 0; end
         ec++;
         isd = opf_valid && (opf_op == 4'd12 || opf_op == 4'd13);
         exp_err = isd && !rb;
         if (opf_valid && !isd)
            sq.push_back('{ec + ST - 1, opf_thread_id, ref_alu(opf_op, opf_op0, opf_op1), opf_hw_lane_mask});
         if (isd && rb) begin
            m_busy = 1; m_due = ec + DW; m_tid = opf_thread_id;
            m_res = ref_alu(opf_op, opf_op0, opf_op1); m_mask = opf_hw_lane_mask;
         end
         if (sq.size() > 0 && sq[0].due == ec) begin
            exp_valid = 1'b1; exp_tid = sq[0].tid; exp_res = sq[0].res; exp_mask = sq[0].mask;
            void'(sq.pop_front());
         end else if (m_busy && ec >= m_due) begin
            exp_valid = 1'b1; exp_tid = m_tid; exp_res = m_res; exp_mask = m_mask;
            m_pres = 1;
         end else begin
            exp_valid = 1'b0;
         end
         exp_ready = !m_busy;
      end
   end

   always @(negedge clk) begin
      chk("valid", int_valid, exp_valid);
      chk("div_ready", int_div_ready, exp_ready);
      chk("error", int_error, exp_err);
      if (exp_valid) begin
         chk("thread_id", int_thread_id, exp_tid);
         chk("result", int_result, exp_res);
         chk("lane_mask", int_hw_lane_mask, exp_mask);
      end
   end

   task automatic set_op(input logic [3:0] op, input logic [TW-1:0] tid, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input logic [NL-1:0] mask);
      opf_valid = 1'b1; opf_op = op; opf_thread_id = tid;
      opf_op0 = a; opf_op1 = b; opf_hw_lane_mask = mask;
   endtask

   function automatic logic [VW-1:0] rand_vec(input bit divisor);
      logic [VW-1:0] v;
      for (int l = 0; l < NL; l++) begin
         case ($urandom_range(0, 3))
            0:       v[l*DW +: DW] = divisor ? 32'd0 : 32'hFFFF_FFFF;
            1:       v[l*DW +: DW] = $urandom & 32'hFF;
            default: v[l*DW +: DW] = $urandom;
         endcase
      end
      return v;
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [TW-1:0] tid, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input int exp_lat, input logic [VW-1:0] exp_r,
                         input string name);
      int  n;
      bit  got;
      @(negedge clk);
      set_op(op, tid, a, b, 4'b1011);
      @(negedge clk);
      opf_valid = 1'b0;
      n = 1;
      got = 0;
      if (op == 4'd12 || op == 4'd13) chk({name, "_busy"}, int_div_ready, 1'b0);
      while (!got && n < 100) begin
         if (int_valid) got = 1;
         else begin @(negedge clk); n++; end
      end
      chk({name, "_latency"}, got ? n : -1, exp_lat);
      chk({name, "_value"}, int_result, exp_r);
      chk({name, "_tid"}, int_thread_id, tid);
      @(negedge clk);
   endtask

   int cnt1, cnt3, pos, got_a;
   logic [3:0] rop;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_valid", int_valid, 1'b0);
      chk("reset_ready", int_div_ready, 1'b1);
      chk("reset_error", int_error, 1'b0);
      reset = 1'b0;

      run_op(4'd0, 2'd1, {32'd0, 32'd3, 32'hFFFF_FFFF, 32'd5}, {32'd0, -32'sd3, 32'd1, 32'd7},
             2, {32'd0, 32'd0, 32'd0, 32'd12}, "add");
      run_op(4'd9, 2'd2, {32'd9, 32'd2, 32'd4, 32'hFFFF_FFFF}, {32'd1, 32'd3, 32'd4, 32'd0},
             2, {32'd0, 32'd0, 32'd0, 32'd5}, "cmplt");
      run_op(4'd12, 2'd3, {4{32'd100}}, {4{32'd7}}, 33, {4{32'd14}}, "divu");
      run_op(4'd13, 2'd0, {4{32'd100}}, {4{32'd7}}, 33, {4{32'd2}}, "remu");
      run_op(4'd12, 2'd1, {4{32'h1234}}, {4{32'd0}}, 33, {4{32'hFFFF_FFFF}}, "divu_by0");
      run_op(4'd13, 2'd2, {4{32'h1234}}, {4{32'd0}}, 33, {4{32'h1234}}, "remu_by0");

      // divider completion while the pipe is saturated with ADDs
      @(negedge clk);
      set_op(4'd12, 2'd3, {32'd77, 32'd1000, 32'd5, 32'd99}, {32'd3, 32'd10, 32'd0, 32'd9}, 4'hF);
      cnt1 = 0; cnt3 = 0; pos = -1;
      for (int j = 0; j < 56; j++) begin
         @(negedge clk);
         if (int_valid && int_thread_id == 2'd1) cnt1++;
         if (int_valid && int_thread_id == 2'd3) begin
            cnt3++;
            if (pos < 0) pos = j;
         end
         if (j < 45) set_op(4'd0, 2'd1, rand_vec(0), rand_vec(0), NL'($urandom));
         else opf_valid = 1'b0;
      end
      chk("stream_add_count", cnt1, 45);
      chk("stream_div_count", cnt3, 1);
      chk("stream_div_slot", pos, 47);

      // second divide while busy is rejected with a one-cycle error
      @(negedge clk);
      set_op(4'd12, 2'd2, {32'd5, 32'd66, 32'd999, 32'd1000}, {4{32'd33}}, 4'hF);
      got_a = 0; pos = -1;
      for (int j = 0; j < 37; j++) begin
         @(negedge clk);
         if (j == 5) chk("busy_error_pulse", int_error, 1'b1);
         if (j == 6) chk("busy_error_clear", int_error, 1'b0);
         if (int_valid && got_a == 0) begin
            got_a = 1; pos = j;
            chk("busy_div_value", int_result, {32'd0, 32'd2, 32'd30, 32'd30});
            chk("busy_div_tid", int_thread_id, 2'd2);
         end
         if (j == 4) set_op(4'd12, 2'd0, {4{32'd50}}, {4{32'd5}}, 4'hF);
         else opf_valid = 1'b0;
      end
      chk("busy_div_slot", pos, 32);

      // reset in the middle of a division
      @(negedge clk);
      set_op(4'd12, 2'd1, {4{32'd12345}}, {4{32'd11}}, 4'hF);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         opf_valid = 1'b0;
      end
      @(negedge clk);
      set_op(4'd0, 2'd2, {4{32'd1}}, {4{32'd2}}, 4'hF);
      @(negedge clk);
      opf_valid = 1'b0;
      @(negedge clk);
      chk("midrun_valid_before", int_valid, 1'b1);
      chk("midrun_ready_before", int_div_ready, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("midrun_valid_after_reset", int_valid, 1'b0);
      chk("midrun_ready_after_reset", int_div_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         enable = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 9) < 7) begin
            rop = ($urandom_range(0, 3) == 0) ? 4'(12 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            set_op(rop, TW'($urandom), rand_vec(0), rand_vec(1), NL'($urandom));
         end else begin
            opf_valid = 1'b0;
         end
      end
      @(negedge clk);
      enable = 1'b1;
      opf_valid = 1'b0;
      repeat (60) @(negedge clk);
      chk("drain_idle_ready", int_div_ready, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/int_pipe_mc.md
Name: int_pipe_mc

Overview:
Parametrised next-generation integer execution pipe. Operates on NUM_LANE lanes of DATA_W bits. Single-cycle ALU operations pass through a configurable-depth result pipeline. Adds an iterative unsigned divide/remainder unit with a ready/busy handshake. Sits between operand fetch and writeback, beside the FP and memory pipes.

Parameters:
TILE_ID, 0, tile index for debug prints only
NUM_LANE, 16, number of hardware lanes (1..32)
DATA_W, 32, lane width in bits (8..64, even)
STAGES, 1, register stages on the single-cycle path (1..4)
TID_W, 2, thread id width

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
enable  in  1  global advance; low freezes all state
opf_valid  in  1  operation issued this cycle
opf_op  in  4  opcode (encoding below)
opf_thread_id  in  TID_W  issuing thread
opf_op0  in  NUM_LANE*DATA_W  source 0, lane i at [i*DATA_W +: DATA_W]
opf_op1  in  NUM_LANE*DATA_W  source 1, same packing
opf_hw_lane_mask  in  NUM_LANE  active lanes
int_div_ready  out  1  divider idle; a DIVU/REMU may issue
int_valid  out  1  result valid
int_thread_id  out  TID_W  thread of the result
int_result  out  NUM_LANE*DATA_W  result lanes
int_hw_lane_mask  out  NUM_LANE  lane mask of the result
int_error  out  1  one-cycle pulse: DIVU/REMU issued while int_div_ready=0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: int_valid=0, int_error=0, int_div_ready=1, divider state IDLE, all pipeline valid bits 0. Data registers are don't-care.
- Opcode encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR (logical), 7 ASHR. Shift amount is op1[$clog2(DATA_W)-1:0].
  - 8 CMPEQ, 9 CMPLT (signed), 10 CMPLT_U. Each lane produces 1 bit. Lane i's bit goes to lane 0 bit i; all other bits and lanes are 0.
  - 11 MOVE: result = op1.
  - 12 DIVU, 13 REMU.
  - 14-15: all-zero result, int_valid still asserted.
- Arithmetic wraps modulo 2^DATA_W. Results are computed in all lanes; the mask is forwarded unchanged and does not gate computation.
- Single-cycle path: an accepted non-div op appears on the outputs exactly STAGES enabled cycles after issue. Back-to-back issue is sustained at one op per cycle.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on opf_valid & (op 12 or 13) & enable. Latches operands, mask, thread id and opcode. int_div_ready drops the next cycle.
  - RUN: radix-2 restoring division, one bit per enabled cycle in all lanes in parallel. After DATA_W iterations -> DONE.
  - DONE: result is presented when the output slot is free. -> IDLE in the same cycle it is presented.
  - Minimum latency from issue to output: DATA_W+1 cycles.
- Divide by zero: quotient = all ones, remainder = dividend. No error flag.
- Output arbitration:
  - If the last pipeline stage is valid, it has priority; the divider stays in DONE until a cycle with an empty last stage.
  - Ops from other threads may issue while the divider is busy. Completion order is therefore not issue order; writeback uses int_thread_id.
- Illegal issue: DIVU/REMU with int_div_ready=0 is dropped. int_error pulses 1 cycle; divider state is untouched.
- enable=0: no state changes, opf_* ignored, outputs hold.
- Reset mid-division: FSM returns to IDLE immediately; the in-flight result is lost.
- Simulation assertion: int_result has no X when int_valid=1.

Test Plan:
1. NUM_LANE=4, DATA_W=32, STAGES=2. ADD lanes (5,7),(0xFFFFFFFF,1),(3,-3),(0,0) -> int_valid 2 cycles later, result {12,0,0,0}.
2. CMPLT signed, op0={-1,4,2,9}, op1={0,4,3,1} -> lane0=0x5 (bits 0 and 2 set), lanes 1-3 = 0.
3. DIVU 100/7 in all lanes -> int_div_ready=0 for the run, then result 14 after 33 cycles. REMU same operands -> 2.
4. DIVU x/0 with x=0x1234 -> quotient 0xFFFFFFFF. REMU x/0 -> 0x1234.
5. Stream ADDs every cycle through divider completion -> divider result is deferred until the first gap. No result is lost or duplicated; per-thread ids are correct.
6. Second DIVU while busy -> int_error 1-cycle pulse, first division still correct. Assert reset mid-RUN -> int_div_ready=1 and int_valid=0 immediately.
